// File: rtl/usb_packet_tx_pkg.sv
// Shared types and constants for the USB packet TX/RX paths.
//   pid_t     : 4-bit USB packet identifier
//   d_port_t  : one beat of a byte stream (data, valid, last)
//   CRC16_*   : CRC16 polynomial, init value and good-packet residual
//   is_data_pid / is_handshake_pid : PID classification helpers
package usb_packet_tx_pkg;

    typedef enum logic [3:0] {
        PID_RSVD  = 4'h0,
        PID_OUT   = 4'h1,
        PID_ACK   = 4'h2,
        PID_DATA0 = 4'h3,
        PID_PING  = 4'h4,
        PID_SOF   = 4'h5,
        PID_NYET  = 4'h6,
        PID_DATA2 = 4'h7,
        PID_SPLIT = 4'h8,
        PID_IN    = 4'h9,
        PID_NAK   = 4'hA,
        PID_DATA1 = 4'hB,
        PID_PRE   = 4'hC,
        PID_SETUP = 4'hD,
        PID_STALL = 4'hE,
        PID_MDATA = 4'hF
    } pid_t;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       last;
    } d_port_t;

    // Polynomial in conventional (x^15 = MSB) form; the hardware shifts
    // LSB first, so it uses the bit-reversed polynomial.
    localparam logic [15:0] CRC16_POLY      = 16'h8005;
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL  = 16'h800D;

    function automatic logic is_data_pid(input pid_t p);
        return (p == PID_DATA0) || (p == PID_DATA1) ||
               (p == PID_DATA2) || (p == PID_MDATA);
    endfunction

    function automatic logic is_handshake_pid(input pid_t p);
        return (p == PID_ACK) || (p == PID_NAK) ||
               (p == PID_STALL) || (p == PID_NYET);
    endfunction

endpackage

// File: rtl/usb_packet_tx_crc16.sv
// USB CRC16 engine, one byte per clock, bits processed LSB first.
//   clk_i    : clock
//   reset_i  : synchronous active-low reset (crc -> FFFF)
//   clear_i  : reload init value (wins over en_i)
//   en_i     : fold data_i into the CRC this cycle
//   data_i   : byte to fold in
//   crc_o    : current register; bit 0 holds the x^15 coefficient
module usb_crc16
    import usb_packet_tx_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q, crc_d;
    logic        fb;

    always_comb begin
        crc_d = crc_q;
        fb    = 1'b0;
        if (clear_i) begin
            crc_d = CRC16_INIT;
        end else if (en_i) begin
            for (int i = 0; i < 8; i++) begin
                fb    = crc_d[0] ^ data_i[i];
                crc_d = crc_d >> 1;
                if (fb) crc_d = crc_d ^ CRC16_POLY_REFL;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) crc_q <= CRC16_INIT;
        else          crc_q <= crc_d;
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/usb_packet_tx.sv
// Device-side USB packet transmitter: PID, payload and CRC16 bytes to the
// SIE, tx_valid held high across the packet, then an idle gap.
//   clk_i, reset_i            : clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o   : packet request handshake (cmd_pid_i, cmd_zlp_i)
//   pl_data_i/pl_valid_i/pl_last_i/pl_ready_o : payload byte stream
//   tx_data_o/tx_valid_o/tx_ready_i           : SIE byte interface
//   busy_o                    : packet or inter-packet gap in progress
//   err_pid_o/err_underrun_o/err_overflow_o   : one-cycle error pulses
module usb_packet_tx
    import usb_packet_tx_pkg::*;
#(
    parameter int MAX_PAYLOAD = 64,
    parameter int IPG_CYCLES  = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [3:0] cmd_pid_i,
    input  logic       cmd_zlp_i,
    input  logic [7:0] pl_data_i,
    input  logic       pl_valid_i,
    input  logic       pl_last_i,
    output logic       pl_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       err_pid_o,
    output logic       err_underrun_o,
    output logic       err_overflow_o
);

    localparam int CNT_W = $clog2(MAX_PAYLOAD + 1);
    localparam int GAP_W = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PID    = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CRC_LO = 3'd3;
    localparam logic [2:0] S_CRC_HI = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;     // pl_last of the byte on tx_data
    logic             hs_q, hs_d;         // handshake packet: PID only
    logic             zlp_q, zlp_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             err_pid_q, err_pid_d;
    logic             err_und_q, err_und_d;
    logic             err_ovf_q, err_ovf_d;

    logic        crc_clr, crc_en;
    logic [15:0] crc;
    pid_t        pid;
    d_port_t     pl;
    logic        want_byte, fetch;

    assign pid = pid_t'(cmd_pid_i);
    assign pl  = '{data: pl_data_i, valid: pl_valid_i, last: pl_last_i};

    // A new payload byte is needed when the SIE takes the PID of a non-ZLP
    // data packet, or takes a payload byte that is neither last nor at the
    // MAX_PAYLOAD limit.
    assign want_byte = (state_q == S_PID && !hs_q && !zlp_q) ||
                       (state_q == S_DATA && !last_q &&
                        cnt_q != CNT_W'(MAX_PAYLOAD));
    assign fetch     = tx_ready_i && want_byte;

    usb_crc16 u_crc (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (crc_clr),
        .en_i    (crc_en),
        .data_i  (pl.data),
        .crc_o   (crc)
    );

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        hs_d       = hs_q;
        zlp_d      = zlp_q;
        gap_d      = gap_q;
        err_pid_d  = 1'b0;
        err_und_d  = 1'b0;
        err_ovf_d  = 1'b0;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    if (is_data_pid(pid) || is_handshake_pid(pid)) begin
                        state_d    = S_PID;
                        tx_valid_d = 1'b1;
                        tx_data_d  = {~cmd_pid_i, cmd_pid_i};
                        crc_clr    = 1'b1;
                        cnt_d      = '0;
                        last_d     = 1'b0;
                        hs_d       = is_handshake_pid(pid);
                        zlp_d      = is_data_pid(pid) && cmd_zlp_i;
                    end else begin
                        err_pid_d = 1'b1;
                    end
                end
            end
            S_PID: begin
                if (tx_ready_i && hs_q) begin
                    tx_valid_d = 1'b0;
                    gap_d      = '0;
                    state_d    = S_GAP;
                end else if (tx_ready_i && zlp_q) begin
                    // CRC is still FFFF, so 00 00 goes out.
                    tx_data_d = ~crc[7:0];
                    state_d   = S_CRC_LO;
                end
            end
            S_DATA: begin
                if (tx_ready_i && !want_byte) begin
                    // Limit reached without pl_last: close the packet anyway.
                    err_ovf_d = !last_q;
                    tx_data_d = ~crc[7:0];
                    state_d   = S_CRC_LO;
                end
            end
            S_CRC_LO: begin
                if (tx_ready_i) begin
                    tx_data_d = ~crc[15:8];
                    state_d   = S_CRC_HI;
                end
            end
            S_CRC_HI: begin
                if (tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    gap_d      = '0;
                    state_d    = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(IPG_CYCLES - 1)) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        // Payload fetch shared by PID and DATA.  A missing byte aborts the
        // packet; the SIE's EOP then leaves it with a bad CRC at the host.
        if (fetch) begin
            if (pl.valid) begin
                tx_data_d = pl.data;
                crc_en    = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                last_d    = pl.last;
                state_d   = S_DATA;
            end else begin
                tx_valid_d = 1'b0;
                err_und_d  = 1'b1;
                gap_d      = '0;
                state_d    = S_GAP;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= S_IDLE;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            hs_q       <= 1'b0;
            zlp_q      <= 1'b0;
            gap_q      <= '0;
            err_pid_q  <= 1'b0;
            err_und_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            hs_q       <= hs_d;
            zlp_q      <= zlp_d;
            gap_q      <= gap_d;
            err_pid_q  <= err_pid_d;
            err_und_q  <= err_und_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

    assign cmd_ready_o    = (state_q == S_IDLE);
    assign busy_o         = (state_q != S_IDLE);
    assign pl_ready_o     = fetch && pl.valid;
    assign tx_data_o      = tx_data_q;
    assign tx_valid_o     = tx_valid_q;
    assign err_pid_o      = err_pid_q;
    assign err_underrun_o = err_und_q;
    assign err_overflow_o = err_ovf_q;

endmodule

// File: tb/tb_usb_packet_tx.sv
// Scoreboard bench for usb_packet_tx: stimulus pushes expected SIE bytes,
// a monitor pops and compares each byte the SIE model accepts.
module tb_usb_packet_tx;
    import usb_packet_tx_pkg::*;

    localparam int MAXP = 4;
    localparam int IPG  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_pid = 4'h0;
    logic       cmd_zlp = 1'b0;
    logic [7:0] pl_data = 8'h0;
    logic       pl_valid = 1'b0;
    logic       pl_last = 1'b0;
    logic       pl_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       busy, err_pid, err_und, err_ovf;

    always #5 clk = ~clk;

    usb_packet_tx #(.MAX_PAYLOAD(MAXP), .IPG_CYCLES(IPG)) dut (
        .clk_i(clk), .reset_i(reset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_pid_i(cmd_pid), .cmd_zlp_i(cmd_zlp),
        .pl_data_i(pl_data), .pl_valid_i(pl_valid), .pl_last_i(pl_last),
        .pl_ready_o(pl_ready),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .busy_o(busy), .err_pid_o(err_pid),
        .err_underrun_o(err_und), .err_overflow_o(err_ovf)
    );

    int tests = 0, fails = 0;
    logic [7:0] exp_q[$];
    logic [8:0] pl_q[$];          // {last, data}
    logic [7:0] pkt[$];
    int n_pid, n_und, n_ovf, n_plr, n_rise;
    bit chk_res = 1'b0;
    bit pl_fire;
    logic prev_v = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference CRC in conventional form: x^15 in bit 15, bits fed LSB first.
    function automatic logic [15:0] crc_nr(input logic [15:0] c, input logic [7:0] b);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[15] ^ b[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h8005;
        end
        return c;
    endfunction

    function automatic logic [15:0] bitrev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    // Expected CRC bytes (low byte first) for a payload.
    task automatic push_crc(input logic [7:0] b[$]);
        logic [15:0] r;
        r = 16'hFFFF;
        foreach (b[i]) r = crc_nr(r, b[i]);
        r = ~bitrev16(r);
        exp_q.push_back(r[7:0]);
        exp_q.push_back(r[15:8]);
    endtask

    // SIE model: accept every other cycle while tx_valid is high.
    always @(posedge clk) begin
        #1;
        if (!reset || tx_ready) tx_ready = 1'b0;
        else if (tx_valid)      tx_ready = 1'b1;
    end

    // Payload source driven from pl_q.
    always begin
        @(negedge clk);
        pl_fire = pl_valid && pl_ready;
        if (pl_fire) n_plr++;
        @(posedge clk);
        #1;
        if (pl_fire && pl_q.size() > 0) void'(pl_q.pop_front());
        if (pl_q.size() > 0) begin
            pl_valid = 1'b1;
            {pl_last, pl_data} = pl_q[0];
        end else begin
            pl_valid = 1'b0;
            pl_last  = 1'b0;
            pl_data  = 8'h0;
        end
    end

    // Monitor: byte scoreboard, error pulse counters, residual check.
    always @(negedge clk) begin
        logic [15:0] r;
        if (err_pid) n_pid++;
        if (err_und) n_und++;
        if (err_ovf) n_ovf++;
        if (tx_valid && !prev_v) begin
            n_rise++;
            pkt.delete();
        end
        if (tx_valid && tx_ready) begin
            pkt.push_back(tx_data);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL tx_byte: got %0h, no byte expected", tx_data);
            end else begin
                check("tx_byte", tx_data, exp_q.pop_front());
            end
        end
        if (!tx_valid && prev_v && chk_res) begin
            r = 16'hFFFF;
            for (int i = 1; i < pkt.size(); i++) r = crc_nr(r, pkt[i]);
            check("crc_residual", r, CRC16_RESIDUAL);
        end
        prev_v = tx_valid;
    end

    task automatic clr_counts();
        n_pid = 0; n_und = 0; n_ovf = 0; n_plr = 0; n_rise = 0;
    endtask

    task automatic send_cmd(input logic [3:0] pid, input bit zlp);
        int n = 0;
        bit acc = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_pid = pid; cmd_zlp = zlp;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 1'b0; cmd_zlp = 1'b0;
        check("cmd_accepted", acc, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!cmd_ready) begin
            fails++;
            $display("FAIL %s_idle: cmd_ready 0 after %0d cycles, expected 1", name, n);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b[$];
        int n, low;
        bit bad;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_pl_ready", pl_ready, 1'b0);
        check("rst_errs", {err_pid, err_und, err_ovf}, 3'b000);
        check("rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b1);

        // ACK: single byte, then IPG low cycles before cmd_ready returns
        // (IPG+1 cycles counting the tx_ready cycle).
        @(posedge clk); #1;
        clr_counts();
        exp_q.push_back(8'hD2);
        send_cmd(PID_ACK, 1'b0);
        n = 0;
        while (!tx_valid && n < 50) begin @(negedge clk); n++; end
        while (tx_valid && n < 50) begin @(negedge clk); n++; end
        check("ack_fell", tx_valid, 1'b0);
        low = 0; bad = 1'b0;
        while (!cmd_ready && low < 100) begin
            if (tx_valid) bad = 1'b1;
            low++;
            @(negedge clk);
        end
        check("ack_ipg_cycles", low, IPG);
        check("ack_gap_tx_low", bad, 1'b0);
        check("ack_exp_empty", exp_q.size(), 0);
        check("ack_one_packet", n_rise, 1);

        // NAK.
        @(posedge clk); #1;
        clr_counts();
        exp_q.push_back(8'h5A);
        send_cmd(PID_NAK, 1'b0);
        wait_idle("nak");
        check("nak_exp_empty", exp_q.size(), 0);

        // DATA0 ZLP: pending payload byte must be left alone.
        clr_counts();
        pl_q.push_back({1'b1, 8'hEE});
        exp_q.push_back(8'hC3); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        chk_res = 1'b1;
        send_cmd(PID_DATA0, 1'b1);
        wait_idle("zlp");
        chk_res = 1'b0;
        check("zlp_exp_empty", exp_q.size(), 0);
        check("zlp_no_pl_ready", n_plr, 0);
        check("zlp_pl_left", pl_q.size(), 1);
        pl_q.delete();
        @(posedge clk); #1;

        // DATA1 00 01 02 03 with pl_last exactly at MAX_PAYLOAD.
        clr_counts();
        b = '{8'h00, 8'h01, 8'h02, 8'h03};
        foreach (b[i]) pl_q.push_back({(i == 3) ? 1'b1 : 1'b0, b[i]});
        exp_q.push_back(8'h4B);
        foreach (b[i]) exp_q.push_back(b[i]);
        push_crc(b);
        chk_res = 1'b1;
        send_cmd(PID_DATA1, 1'b0);
        wait_idle("data1");
        chk_res = 1'b0;
        check("data1_exp_empty", exp_q.size(), 0);
        check("data1_pl_ready", n_plr, 4);
        check("data1_no_ovf", n_ovf, 0);

        // Underrun on the second fetch.
        clr_counts();
        pl_q.push_back({1'b0, 8'h55});
        exp_q.push_back(8'hC3); exp_q.push_back(8'h55);
        send_cmd(PID_DATA0, 1'b0);
        wait_idle("und");
        check("und_pulse", n_und, 1);
        check("und_pl_ready", n_plr, 1);
        check("und_exp_empty", exp_q.size(), 0);
        check("und_one_packet", n_rise, 1);

        // Overflow: 6-byte stream, only MAX_PAYLOAD consumed.
        clr_counts();
        b = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        foreach (b[i]) pl_q.push_back({1'b0, b[i]});
        pl_q.push_back({1'b0, 8'hA4});
        pl_q.push_back({1'b1, 8'hA5});
        exp_q.push_back(8'hC3);
        foreach (b[i]) exp_q.push_back(b[i]);
        push_crc(b);
        chk_res = 1'b1;
        send_cmd(PID_DATA0, 1'b0);
        wait_idle("ovf");
        chk_res = 1'b0;
        check("ovf_pulse", n_ovf, 1);
        check("ovf_pl_ready", n_plr, MAXP);
        check("ovf_pl_left", pl_q.size(), 2);
        check("ovf_exp_empty", exp_q.size(), 0);
        pl_q.delete();
        @(posedge clk); #1;

        // Token PID rejected.
        clr_counts();
        send_cmd(PID_IN, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("in_err_pid", n_pid, 1);
        check("in_no_packet", n_rise, 0);

        // Reset in the middle of a data packet.
        clr_counts();
        b = '{8'h10, 8'h11, 8'h12};
        foreach (b[i]) pl_q.push_back({(i == 2) ? 1'b1 : 1'b0, b[i]});
        exp_q.push_back(8'hC3);
        foreach (b[i]) exp_q.push_back(b[i]);
        push_crc(b);
        send_cmd(PID_DATA0, 1'b0);
        n = 0;
        while (n_plr < 2 && n < 100) begin @(posedge clk); #1; n++; end
        check("mid_reached_data", n_plr >= 2, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_tx_valid", tx_valid, 1'b0);
        check("mid_tx_data", tx_data, 8'h00);
        check("mid_pl_ready", pl_ready, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_errs", {err_pid, err_und, err_ovf}, 3'b000);
        @(posedge clk); #1;
        exp_q.delete();
        pl_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid_cmd_ready", cmd_ready, 1'b1);
        check("mid_no_err_pulse", n_und + n_ovf + n_pid, 0);

        // Recovery after reset.
        @(posedge clk); #1;
        clr_counts();
        exp_q.push_back(8'h1E);
        send_cmd(PID_STALL, 1'b0);
        wait_idle("stall");
        check("stall_exp_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/usb_packet_tx.md
Name: usb_packet_tx

Overview:
Device-side USB packet transmitter, sitting between the USB controller and the SIE TX interface (tx_data/tx_valid/tx_ready). It accepts a packet command (PID plus an optional payload byte stream) and emits PID, payload and CRC16 bytes. It drives tx_valid high across the whole packet so the SIE frames it with SYNC and EOP. It also enforces a minimum inter-packet idle gap.

Parameters:
MAX_PAYLOAD, 64, maximum payload bytes per data packet (1..1023).
IPG_CYCLES, 16, minimum clk cycles tx_valid stays low between packets (≥1).

Ports:
clk  in  1  system clock (24 MHz)
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  packet request
cmd_ready  out  1  request accepted when cmd_valid&cmd_ready
cmd_pid  in  4  pid_t; allowed: DATA0, DATA1, DATA2, MDATA, ACK, NAK, STALL, NYET
cmd_zlp  in  1  data PID only: send zero-length payload (payload stream ignored)
pl_data  in  8  payload byte
pl_valid  in  1  payload byte available
pl_last  in  1  marks final payload byte
pl_ready  out  1  payload byte consumed this cycle
tx_data  out  8  byte to SIE
tx_valid  out  1  rise: SYNC, high: send, fall: EOP
tx_ready  in  1  one-cycle pulse: SIE has taken tx_data
busy  out  1  packet in progress or IPG running
err_pid  out  1  one-cycle pulse: command with token/SPECIAL PID rejected
err_underrun  out  1  one-cycle pulse: payload not available when needed; packet aborted
err_overflow  out  1  one-cycle pulse: MAX_PAYLOAD reached without pl_last

Behaviour:
- Reset (reset==0 at clk edge): state IDLE, tx_valid=0, tx_data=0, pl_ready=0, all err_*=0, IPG counter=0, CRC=16'hFFFF. cmd_ready=1 one cycle after reset is released.
- States: IDLE, PID, DATA, CRC_LO, CRC_HI, GAP.
- cmd_ready = (state==IDLE). When cmd_valid&cmd_ready:
  - invalid PID: err_pid pulses next cycle; state stays IDLE.
  - valid PID: next cycle state=PID, tx_valid=1, tx_data={~pid,pid}, CRC=FFFF, byte count=0.
- PID on tx_ready:
  - handshake PID: tx_valid=0 next cycle, go GAP.
  - data PID with cmd_zlp: go CRC_LO (CRC stays FFFF, so 00 00 is sent).
  - otherwise fetch first payload byte.
- Fetch, in PID/DATA on tx_ready:
  - pl_ready = tx_ready & pl_valid, combinational.
  - pl_valid=1: tx_data<=pl_data, CRC updated with the byte, count+1, state DATA.
  - pl_valid=0: underrun. tx_valid=0 next cycle, err_underrun pulse, go GAP. The SIE ends the packet with EOP and the host discards it on CRC error.
- DATA on tx_ready:
  - last byte flag set (pl_last latched at fetch): go CRC_LO, tx_data=~crc[7:0].
  - count==MAX_PAYLOAD without last: err_overflow pulse; treat as last and go CRC_LO. Further pl bytes are not consumed and remain for upstream to flush.
  - else fetch next byte.
- CRC_LO on tx_ready: tx_data=~crc[15:8], go CRC_HI. CRC_HI on tx_ready: tx_valid=0 next cycle, go GAP.
- CRC16: poly x^16+x^15+x^2+1 (16'h8005), init FFFF, processed LSB first, complemented for transmission, low byte first. Residual over payload+CRC = 16'h800D.
- GAP: counts IPG_CYCLES with tx_valid=0, then IDLE. busy = (state != IDLE).
- tx_data is held stable while tx_valid=1 until tx_ready. tx_ready while tx_valid=0 is ignored.
- Reset mid-packet: tx_valid drops at the next edge and the packet is lost; no error pulse.
- Simultaneous cmd_valid and GAP: cmd waits; no loss.

Decomposition:
- Shared package (types): pid_t (already holds IN, etc.), d_port_t, CRC16 poly/init/residual constants, and an is_handshake_pid/is_data_pid helper function.
- Sub-module usb_crc16: clear, byte enable, 8-bit data in, 16-bit crc out, one byte per clk. The RX path reuses it for DATA-packet checking.

Test Plan:
- ACK command → tx_data 8'hD2 with tx_valid high; after one tx_ready, tx_valid low; cmd_ready returns after IPG_CYCLES+1 cycles.
- DATA0 with cmd_zlp → bytes C3, 00, 00 across three tx_ready pulses; tx_valid then falls.
- DATA1 with payload 00 01 02 03 (pl_last on 03) → bytes 4B, 00, 01, 02, 03, crcL, crcH; the bench model's CRC16 over the 6 bytes after the PID gives residual 16'h800D; pl_ready pulses exactly 4 times.
- Payload with pl_valid=0 at the second fetch → err_underrun pulses once, tx_valid falls, FSM goes to GAP, no further pl_ready.
- MAX_PAYLOAD=4 with 6-byte stream → 4 bytes sent plus valid CRC, err_overflow pulses once, bytes 5–6 not consumed.
- cmd_pid=IN (4'h9) → err_pid pulses, tx_valid stays 0. Separately, reset asserted mid-DATA → tx_valid=0 next edge and all outputs at reset values.
